// File: rtl/ysyx_23060332_lsu.sv
// rtl/ysyx_23060332_lsu.sv - single-request load/store unit between EXU, data memory and WBU
// Optional feature macro: LSU_MISALIGN_ERR_EN (trap misaligned / illegal-size requests)
module ysyx_23060332_lsu #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_valid,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              trap;
  logic              in_access;
  logic              in_resp;
  logic [1:0]        off;
  logic [3:0]        base_mask;
  logic [3:0]        lane_mask;
  logic [DATA_W-1:0] wdata_shift;
  logic [DATA_W-1:0] rdata_shift;
  logic [DATA_W-1:0] load_ext;

`ifdef LSU_MISALIGN_ERR_EN
  assign trap = (req_size == 2'b11) ||
                (req_size == 2'b01 && req_addr[0]) ||
                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign off       = addr_q[1:0];

  // Size 11 only reaches ACCESS when trapping is disabled, where it acts as a word.
  always_comb begin
    base_mask = 4'b1111;
    case (size_q)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // Lanes shifted past byte 3 fall off, truncating a boundary-crossing access.
  assign lane_mask   = base_mask << off;
  assign wdata_shift = wdata_q << {off, 3'b000};
  assign rdata_shift = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = rdata_shift;
    case (size_q)
      2'b00:   load_ext = {{(DATA_W-8){~uns_q & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_ext = {{(DATA_W-16){~uns_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          if (trap) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            cnt_d   = 4'(MEM_LATENCY - 1);
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          rdata_d = wen_q ? '0 : load_ext;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The write strobe fires only on the last held cycle so a store lands once.
  assign req_ready = (state_q == IDLE);
  assign mem_valid = in_access;
  assign mem_ren   = in_access & ~wen_q;
  assign mem_wen   = in_access & wen_q & (cnt_q == 4'd0);
  assign mem_raddr = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_waddr = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = in_access ? wdata_shift : '0;
  assign mem_wmask = in_access ? {4'b0000, lane_mask} : 8'h00;
  assign rsp_valid = in_resp;
  assign rsp_rdata = in_resp ? rdata_q : '0;
  assign rsp_err   = in_resp & err_q;

endmodule

// File: doc/ysyx_23060332_lsu.md
Name: ysyx_23060332_lsu

Overview:
Load/store unit directly upstream of the DPI-backed data memory stage. Accepts one load or store request at a time from the EXU over a valid/ready handshake. Drives the memory port with word-aligned addresses, byte masks and lane-shifted store data. Returns sign- or zero-extended load data (or a store completion) to the WBU over a second valid/ready handshake.

Parameters:
MEM_LATENCY, 1, cycles the memory port is held per access (legal range 1..15)
ADDR_W, 32, address width
DATA_W, 32, data width (RV32)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous and active-low
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (LBU/LHU)
mem_valid  out  1  memory access valid
mem_ren  out  1  memory read enable
mem_raddr  out  ADDR_W  word-aligned read address
mem_wen  out  1  memory write enable
mem_waddr  out  ADDR_W  word-aligned write address
mem_wdata  out  DATA_W  lane-shifted store data
mem_wmask  out  8  byte-enable mask (bits 7:4 always 0)
mem_rdata  in  DATA_W  combinational read data, full aligned word
rsp_valid  out  1  response valid to WBU
rsp_ready  in  1  WBU accepts response
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-size access

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE. All outputs are 0 in reset except req_ready, which is 1 in IDLE.
- IDLE: req_ready = 1. On req_valid, register wen, addr, wdata, size, unsigned; off = addr[1:0].
  - Misaligned request (half with off[0] = 1, word with off != 0, or size 11): go to RESP with rsp_err = 1 and rsp_rdata = 0. No memory access is made.
  - Otherwise go to ACCESS and load cnt = MEM_LATENCY-1.
- ACCESS: req_ready = 0; mem_valid = 1; mem_raddr = mem_waddr = {addr[ADDR_W-1:2], 2'b00}.
  - Load: mem_ren = 1 for every ACCESS cycle.
  - Store: mem_wen = 1 only in the final cycle (cnt == 0), so memory is written exactly once.
  - mem_wmask = (byte 0001, half 0011, word 1111) << off.
  - mem_wdata = req_wdata << (8*off).
  - cnt decrements each cycle. When cnt == 0: capture load data, then go to RESP.
- Load extraction: shifted = mem_rdata >> (8*off); take bits [7:0] or [15:0]; sign-extend unless req_unsigned; word passes through unchanged.
- RESP: rsp_valid = 1, with rsp_rdata and rsp_err held stable. When rsp_ready = 1, return to IDLE.
  - No request is accepted in the RESP cycle, so throughput is at most one access per MEM_LATENCY+2 cycles.
- Memory outputs are decoded from state and are 0 outside ACCESS. mem_waddr and mem_raddr carry the same value.
- Reset mid-operation: immediately returns to IDLE and forces mem_wen, mem_ren and rsp_valid to 0.
  - A store whose final ACCESS cycle had not yet completed is never written.
  - A pending response is dropped.
- req_* inputs are ignored outside IDLE.

Optional Feature:
LSU_MISALIGN_ERR_EN
- Defined: misaligned and illegal-size requests are trapped as described above (rsp_err = 1, no memory access).
- Undefined: rsp_err is tied to 0. The address is used as-is, with bits [1:0] still selecting the lane. Size 11 is treated as word. Halfword lanes that cross the word boundary are truncated to the in-word bytes, and the memory access always occurs.

Test Plan:
- MEM_LATENCY=1: store word 0xDEADBEEF at 0x80000004 → one cycle with mem_wen = 1, waddr 0x80000004, wmask 0x0F, wdata 0xDEADBEEF; then rsp_valid with rsp_rdata 0.
- Memory word 0x8899AABB at 0x80000000: LB at 0x80000001 → rsp_rdata 0xFFFFFFAA; LBU → 0x000000AA; LH at 0x80000002 → 0xFFFF8899; LHU → 0x00008899.
- Store byte 0x5A at 0x80000003 → wmask 0x08, wdata 0x5A000000. Store half 0x1234 at 0x80000002 → wmask 0x0C, wdata 0x12340000.
- LSU_MISALIGN_ERR_EN defined: LW at 0x80000002 → no mem_valid pulse; rsp_valid with rsp_err = 1, rsp_rdata 0. Size 11 at 0x80000000 → same response.
- MEM_LATENCY=3 with rsp_ready held low 4 cycles: mem_valid high exactly 3 cycles; store mem_wen high only on the 3rd; rsp_valid and data held stable until rsp_ready; req_ready low throughout.
- Assert rst_n low during the 2nd ACCESS cycle of a MEM_LATENCY=3 store → mem_wen never asserted; after release, FSM in IDLE with req_ready = 1 and rsp_valid = 0.
